sound_player: RTL and testbench

//  Audio back-end for the bouncing-logo screen: consumes the mute/code_sound event pair from the

---
 rtl/sound_player_if.sv | 14 +
 rtl/sound_player.sv | 133 +++++++++++++
 tb/tb_sound_player.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sound_player_if.sv
// Event/speaker bundle between the motion block and the sound back-end.
//   mute        : 1 = silence; a falling edge starts the current code_sound
//   code_sound  : 00 ping, 01 pong, 10 go, 11 stop
//   speaker     : square-wave drive, 0 whenever silent
//   busy        : 1 while a note or inter-note gap is in progress
interface sound_player_if;
    logic       mute;
    logic [1:0] code_sound;
    logic       speaker;
    logic       busy;

    modport master (output mute, output code_sound, input speaker, input busy);
    modport slave  (input mute, input code_sound, output speaker, output busy);
endinterface

// File: rtl/sound_player.sv
// Square-wave sound player for the bouncing-logo screen.
// Ping/pong play one note; go/stop play two notes separated by a silent gap.
// A new event pre-empts the sound in progress; mute silences on the next edge.
// Ports:
//   clk : system clock
//   clr : asynchronous active-low reset
//   bus : sound_player_if.slave (mute, code_sound in; speaker, busy out)
//
// state | meaning
// IDLE  | silent, waiting for an event
// NOTE1 | first (or only) note sounding
// GAP   | silence between the two notes of go/stop
// NOTE2 | second note of go/stop sounding
module sound_player #(
    parameter logic [15:0] HALF_LOW  = 16'd27272,
    parameter logic [15:0] HALF_MID  = 16'd13636,
    parameter logic [15:0] HALF_HIGH = 16'd6818,
    parameter logic [23:0] NOTE_LEN  = 24'd1200000,
    parameter logic [23:0] GAP_LEN   = 24'd240000
) (
    input  logic           clk,
    input  logic           clr,
    sound_player_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, NOTE1, GAP, NOTE2} state_t;

    state_t      state, state_d;
    logic        mute_q;
    logic [1:0]  code_q;
    logic [1:0]  code_l, code_d;
    logic [15:0] tone, tone_d;
    logic [23:0] dur, dur_d;
    logic        spk, spk_d;
    logic        trig;

    // Half-period for a code's first or second note.
    function automatic logic [15:0] note_half(input logic [1:0] code, input logic second);
        logic [15:0] h;
        case (code)
            2'b00:   h = HALF_HIGH;
            2'b01:   h = HALF_MID;
            2'b10:   h = second ? HALF_HIGH : HALF_LOW;
            default: h = second ? HALF_LOW : HALF_HIGH;
        endcase
        return h;
    endfunction

    // A new event is mute falling or a code change while unmuted.
    assign trig = !bus.mute && (mute_q || (bus.code_sound != code_q));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            mute_q <= 1'b1;
            code_q <= 2'b00;
            code_l <= 2'b00;
            tone   <= 16'd0;
            dur    <= 24'd0;
            spk    <= 1'b0;
        end else begin
            state  <= state_d;
            mute_q <= bus.mute;
            code_q <= bus.code_sound;
            code_l <= code_d;
            tone   <= tone_d;
            dur    <= dur_d;
            spk    <= spk_d;
        end
    end

    always_comb begin
        state_d = state;
        code_d  = code_l;
        tone_d  = tone;
        dur_d   = dur;
        spk_d   = spk;
        if (bus.mute) begin
            state_d = IDLE;
            spk_d   = 1'b0;
            tone_d  = 16'd0;
            dur_d   = 24'd0;
        end else if (trig) begin
            state_d = NOTE1;
            code_d  = bus.code_sound;
            spk_d   = 1'b1;
            tone_d  = note_half(bus.code_sound, 1'b0) - 16'd1;
            dur_d   = NOTE_LEN - 24'd1;
        end else begin
            case (state)
                NOTE1, NOTE2: begin
                    if (dur == 24'd0) begin
                        spk_d  = 1'b0;
                        tone_d = 16'd0;
                        // code bit 1 marks the two-note motifs (go/stop)
                        if (state == NOTE1 && code_l[1]) begin
                            state_d = GAP;
                            dur_d   = GAP_LEN - 24'd1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        dur_d = dur - 24'd1;
                        if (tone == 16'd0) begin
                            spk_d  = !spk;
                            tone_d = note_half(code_l, state == NOTE2) - 16'd1;
                        end else begin
                            tone_d = tone - 16'd1;
                        end
                    end
                end
                GAP: begin
                    spk_d = 1'b0;
                    if (dur == 24'd0) begin
                        state_d = NOTE2;
                        spk_d   = 1'b1;
                        tone_d  = note_half(code_l, 1'b1) - 16'd1;
                        dur_d   = NOTE_LEN - 24'd1;
                    end else begin
                        dur_d = dur - 24'd1;
                    end
                end
                default: begin
                    spk_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.speaker = spk;
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_sound_player.sv
module tb_sound_player;

    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   bad   = 0;

    sound_player_if bus ();

    sound_player #(
        .HALF_LOW (16'd8),
        .HALF_MID (16'd4),
        .HALF_HIGH(16'd2),
        .NOTE_LEN (24'd32),
        .GAP_LEN  (24'd8)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected speaker level k cycles into a note of half-period h.
    function automatic logic tone_bit(input int k, input int h);
        return ((k / h) % 2) == 0;
    endfunction

    // Expected (busy, speaker) k cycles after a trigger edge for each code.
    function automatic logic [1:0] expect_code(input logic [1:0] code, input int k);
        int h1, h2;
        case (code)
            2'b00:   begin h1 = 2; h2 = 0; end
            2'b01:   begin h1 = 4; h2 = 0; end
            2'b10:   begin h1 = 8; h2 = 2; end
            default: begin h1 = 2; h2 = 8; end
        endcase
        if (k < 32) return {1'b1, tone_bit(k, h1)};
        if (h2 == 0) return 2'b00;
        if (k < 40) return 2'b10;
        if (k < 72) return {1'b1, tone_bit(k - 40, h2)};
        return 2'b00;
    endfunction

    task automatic test_reset();
        logic [1:0] obs;
        #1;
        obs = {bus.busy, bus.speaker};
        total++;
        if (obs !== 2'b00) begin
            bad++;
            $display("FAIL reset_async busy/speaker=%b expected=00", obs);
        end
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) bus.code_sound = 2'b10;
            step();
            obs = {bus.busy, bus.speaker};
            total++;
            if (obs !== 2'b00) begin
                bad++;
                $display("FAIL muted_idle cycle=%0d busy/speaker=%b expected=00", i, obs);
            end
        end
    endtask

    task automatic run_check(input string name, input logic [1:0] code, input int k0, input int k1);
        logic [1:0] obs, exp;
        for (int k = k0; k <= k1; k++) begin
            step();
            obs = {bus.busy, bus.speaker};
            exp = expect_code(code, k);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s k=%0d busy/speaker=%b expected=%b", name, k, obs, exp);
            end
        end
    endtask

    task automatic test_ping();
        bus.code_sound = 2'b00;
        bus.mute = 1'b0;
        run_check("ping", 2'b00, 0, 39);
    endtask

    task automatic test_go();
        bus.mute = 1'b1;
        step();
        bus.code_sound = 2'b10;
        bus.mute = 1'b0;
        run_check("go", 2'b10, 0, 75);
    endtask

    task automatic test_preempt();
        bus.mute = 1'b1;
        step();
        bus.mute = 1'b0;
        run_check("preempt_go", 2'b10, 0, 10);
        bus.code_sound = 2'b01;
        run_check("preempt_pong", 2'b01, 0, 35);
    endtask

    task automatic test_mute_replay();
        logic [1:0] obs;
        bus.code_sound = 2'b00;
        run_check("ping_pre_mute", 2'b00, 0, 4);
        bus.mute = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            obs = {bus.busy, bus.speaker};
            total++;
            if (obs !== 2'b00) begin
                bad++;
                $display("FAIL mute_silence cycle=%0d busy/speaker=%b expected=00", i, obs);
            end
        end
        bus.mute = 1'b0;
        run_check("ping_replay", 2'b00, 0, 35);
    endtask

    task automatic test_async_clr();
        logic [1:0] obs;
        bus.mute = 1'b1;
        step();
        bus.code_sound = 2'b11;
        bus.mute = 1'b0;
        run_check("stop", 2'b11, 0, 45);
        #2;
        clr = 1'b0;
        #1;
        obs = {bus.busy, bus.speaker};
        total++;
        if (obs !== 2'b00) begin
            bad++;
            $display("FAIL clr_immediate busy/speaker=%b expected=00", obs);
        end
        step();
        obs = {bus.busy, bus.speaker};
        total++;
        if (obs !== 2'b00) begin
            bad++;
            $display("FAIL clr_held busy/speaker=%b expected=00", obs);
        end
        clr = 1'b1;
        run_check("stop_after_clr", 2'b11, 0, 10);
    endtask

    initial begin
        clr = 1'b0;
        bus.mute = 1'b1;
        bus.code_sound = 2'b00;
        test_reset();
        test_ping();
        test_go();
        test_preempt();
        test_mute_replay();
        test_async_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
